// File: rtl/bmc_frame_decoder.sv
// ---------------------------------------------------------------------------
// bmc_frame_decoder
//
// Biphase-Mark frame decoder for one TS4231 light-sensor channel (D/E pair).
// The raw D and E pins are synchronised internally. Edge-to-edge intervals
// on D are classified as glitch / short (half bit) / long (full bit) /
// timeout. Completed frames go to a valid/ready output register, stamped
// with the system time of the frame's first D edge.
//
// Optional build macro:
//   BMC_ERROR_COUNTERS_EN  when defined, err_count is a saturating 16-bit
//                          count of decode errors; otherwise err_count is 0.
//
// Ports:
//   clk_96MHz      in   system clock
//   reset          in   synchronous, active-high
//   enable         in   decoder enable; low forces IDLE
//   d_in           in   sensor D line, asynchronous
//   e_in           in   sensor E line (envelope, active-low), asynchronous
//   sys_timestamp  in   free-running system time
//   data_out       out  decoded frame, MSB = first received bit
//   frame_ts       out  sys_timestamp at the frame's first D edge
//   data_valid     out  output register holds an unread frame
//   data_ready     in   consumer accepts frame
//   overflow       out  sticky: frame dropped because output register full
//   err_pulse      out  one-cycle pulse on a decode error
//   err_code       out  last error: 0 none, 1 envelope lost, 2 timeout,
//                       3 phase violation
//   err_count      out  saturating error count (optional, see above)
//   busy           out  state != IDLE
//
// States:
//   state   | meaning
//   IDLE    | envelope inactive, waiting for E low
//   ARM     | envelope active, waiting for the first D edge
//   SAMPLE  | measuring D intervals and shifting in bits
//   DONE    | one cycle: hand frame to output register or flag overflow
//   HOLDOFF | post-frame blanking, inputs ignored
//   ERROR   | one cycle: raise err_pulse and latch err_code
// ---------------------------------------------------------------------------
module bmc_frame_decoder #(
    parameter int NB_BITS       = 17,
    parameter int TS_WIDTH      = 24,
    parameter int MIN_TICKS     = 4,
    parameter int FAST_MAX      = 11,
    parameter int SLOW_MAX      = 24,
    parameter int HOLDOFF_TICKS = 14000
) (
    input  logic                clk_96MHz,
    input  logic                reset,
    input  logic                enable,
    input  logic                d_in,
    input  logic                e_in,
    input  logic [TS_WIDTH-1:0] sys_timestamp,
    output logic [NB_BITS-1:0]  data_out,
    output logic [TS_WIDTH-1:0] frame_ts,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                overflow,
    output logic                err_pulse,
    output logic [1:0]          err_code,
    output logic [15:0]         err_count,
    output logic                busy
);

    localparam int TW = $clog2(SLOW_MAX + 2);
    localparam int BW = $clog2(NB_BITS + 1);
    localparam int HW = (HOLDOFF_TICKS > 2) ? $clog2(HOLDOFF_TICKS) : 1;

    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_MIN  = TW'(MIN_TICKS);
    localparam logic [TW-1:0] TICK_FAST = TW'(FAST_MAX);
    localparam logic [TW-1:0] TICK_SLOW = TW'(SLOW_MAX);
    localparam logic [TW-1:0] TICK_SAT  = {TW{1'b1}};
    localparam logic [BW-1:0] BIT_LAST  = BW'(NB_BITS - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLDOFF_TICKS - 1);

    localparam logic [1:0] ERR_ENV     = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_PHASE   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_DONE    = 3'd3,
        ST_HOLDOFF = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic d_meta_q, d_meta_d;
    logic d_s_q, d_s_d;
    logic d_prev_q, d_prev_d;
    logic e_meta_q, e_meta_d;
    logic e_s_q, e_s_d;

    logic [TW-1:0]       tick_q, tick_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                half_q, half_d;
    logic [NB_BITS-1:0]  shift_q, shift_d;
    logic [TS_WIDTH-1:0] ts_shadow_q, ts_shadow_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [1:0]          err_sel_q, err_sel_d;

    logic [NB_BITS-1:0]  data_out_q, data_out_d;
    logic [TS_WIDTH-1:0] frame_ts_q, frame_ts_d;
    logic                data_valid_q, data_valid_d;
    logic                overflow_q, overflow_d;
    logic                err_pulse_q, err_pulse_d;
    logic [1:0]          err_code_q, err_code_d;

    logic d_edge;
    logic bit_done;
    logic bit_val;

    assign d_edge = d_s_q ^ d_prev_q;

    always_comb begin
        d_meta_d     = d_in;
        d_s_d        = d_meta_q;
        d_prev_d     = d_s_q;
        e_meta_d     = e_in;
        e_s_d        = e_meta_q;

        state_d      = state_q;
        tick_d       = tick_q;
        bit_cnt_d    = bit_cnt_q;
        half_d       = half_q;
        shift_d      = shift_q;
        ts_shadow_d  = ts_shadow_q;
        hold_cnt_d   = hold_cnt_q;
        err_sel_d    = err_sel_q;

        data_out_d   = data_out_q;
        frame_ts_d   = frame_ts_q;
        data_valid_d = data_valid_q;
        overflow_d   = overflow_q;
        err_pulse_d  = 1'b0;
        err_code_d   = err_code_q;

        bit_done     = 1'b0;
        bit_val      = 1'b0;

        // Consumer handshake runs regardless of decoder state; a DONE load
        // in the same cycle overrides the clear below.
        if (data_valid_q && data_ready) begin
            data_valid_d = 1'b0;
        end

        if (!enable) begin
            state_d   = ST_IDLE;
            tick_d    = '0;
            bit_cnt_d = '0;
            half_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!e_s_q) begin
                        state_d = ST_ARM;
                    end
                end

                ST_ARM: begin
                    if (e_s_q) begin
                        state_d = ST_IDLE;
                    end else if (d_edge) begin
                        ts_shadow_d = sys_timestamp;
                        tick_d      = TICK_ONE;
                        bit_cnt_d   = '0;
                        half_d      = 1'b0;
                        state_d     = ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    if (e_s_q) begin
                        err_sel_d = ERR_ENV;
                        state_d   = ST_ERROR;
                    end else if (tick_q > TICK_SLOW) begin
                        err_sel_d = ERR_TIMEOUT;
                        state_d   = ST_ERROR;
                    end else if (d_edge && (tick_q >= TICK_MIN)) begin
                        tick_d = TICK_ONE;
                        if (tick_q <= TICK_FAST) begin
                            // Two short intervals in a row make one '1' bit.
                            if (!half_q) begin
                                half_d = 1'b1;
                            end else begin
                                half_d   = 1'b0;
                                bit_done = 1'b1;
                                bit_val  = 1'b1;
                            end
                        end else begin
                            // A long interval after a lone half is illegal.
                            if (half_q) begin
                                err_sel_d = ERR_PHASE;
                                state_d   = ST_ERROR;
                            end else begin
                                bit_done = 1'b1;
                                bit_val  = 1'b0;
                            end
                        end
                    end else begin
                        // Sub-MIN_TICKS edges are glitches: keep timing the
                        // current interval as if they never happened.
                        if (tick_q != TICK_SAT) begin
                            tick_d = tick_q + TICK_ONE;
                        end
                    end

                    if (bit_done) begin
                        shift_d   = {shift_q[NB_BITS-2:0], bit_val};
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    if (!data_valid_q || data_ready) begin
                        data_out_d   = shift_q;
                        frame_ts_d   = ts_shadow_q;
                        data_valid_d = 1'b1;
                    end else begin
                        overflow_d = 1'b1;
                    end
                    hold_cnt_d = HOLD_INIT;
                    state_d    = ST_HOLDOFF;
                end

                ST_HOLDOFF: begin
                    if (hold_cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q - HW'(1);
                    end
                end

                ST_ERROR: begin
                    err_pulse_d = 1'b1;
                    err_code_d  = err_sel_q;
                    state_d     = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            // E synchroniser resets to the inactive (high) level so the
            // decoder cannot arm before the real pin level has propagated.
            d_meta_q     <= 1'b0;
            d_s_q        <= 1'b0;
            d_prev_q     <= 1'b0;
            e_meta_q     <= 1'b1;
            e_s_q        <= 1'b1;
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            bit_cnt_q    <= '0;
            half_q       <= 1'b0;
            shift_q      <= '0;
            ts_shadow_q  <= '0;
            hold_cnt_q   <= '0;
            err_sel_q    <= 2'd0;
            data_out_q   <= '0;
            frame_ts_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            d_meta_q     <= d_meta_d;
            d_s_q        <= d_s_d;
            d_prev_q     <= d_prev_d;
            e_meta_q     <= e_meta_d;
            e_s_q        <= e_s_d;
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_cnt_q    <= bit_cnt_d;
            half_q       <= half_d;
            shift_q      <= shift_d;
            ts_shadow_q  <= ts_shadow_d;
            hold_cnt_q   <= hold_cnt_d;
            err_sel_q    <= err_sel_d;
            data_out_q   <= data_out_d;
            frame_ts_q   <= frame_ts_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            err_pulse_q  <= err_pulse_d;
            err_code_q   <= err_code_d;
        end
    end

`ifdef BMC_ERROR_COUNTERS_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if ((state_q == ST_ERROR) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_96MHz) begin
        if (reset) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`else
    assign err_count = 16'd0;
`endif

    assign data_out   = data_out_q;
    assign frame_ts   = frame_ts_q;
    assign data_valid = data_valid_q;
    assign overflow   = overflow_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bmc_frame_decoder.sv
// Testbench for bmc_frame_decoder: directed BMC frames with a scoreboard of
// expected {data, timestamp} pairs checked by an independent output monitor.
module tb_bmc_frame_decoder;

    localparam int NB   = 17;
    localparam int TSW  = 24;
    localparam int HOLD = 64;
    localparam int HALF = 8;
    localparam int FULL = 16;

    logic            clk_96MHz = 1'b0;
    logic            reset;
    logic            enable;
    logic            d_in;
    logic            e_in;
    logic [TSW-1:0]  sys_timestamp;
    logic [NB-1:0]   data_out;
    logic [TSW-1:0]  frame_ts;
    logic            data_valid;
    logic            data_ready;
    logic            overflow;
    logic            err_pulse;
    logic [1:0]      err_code;
    logic [15:0]     err_count;
    logic            busy;

    typedef struct {
        logic [NB-1:0]  data;
        logic [TSW-1:0] ts;
    } exp_t;

    exp_t exp_q[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int err_seen = 0;

    bmc_frame_decoder #(
        .NB_BITS      (NB),
        .TS_WIDTH     (TSW),
        .MIN_TICKS    (4),
        .FAST_MAX     (11),
        .SLOW_MAX     (24),
        .HOLDOFF_TICKS(HOLD)
    ) dut (
        .clk_96MHz    (clk_96MHz),
        .reset        (reset),
        .enable       (enable),
        .d_in         (d_in),
        .e_in         (e_in),
        .sys_timestamp(sys_timestamp),
        .data_out     (data_out),
        .frame_ts     (frame_ts),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .overflow     (overflow),
        .err_pulse    (err_pulse),
        .err_code     (err_code),
        .err_count    (err_count),
        .busy         (busy)
    );

    always #5 clk_96MHz = ~clk_96MHz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // All inputs, including the timestamp, change on the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_96MHz);
            sys_timestamp = sys_timestamp + 1'b1;
        end
    endtask

    // Sends the first nbits of val MSB-first as BMC, preceded by the start
    // edge. A glitch (edges 1 and 3 cycles after the bit boundary) is placed
    // in bit glitch_bit when it is in range.
    task automatic send_frame(input logic [NB-1:0] val, input int nbits,
                              input int glitch_bit, output logic [TSW-1:0] ts_exp);
        step(1);
        d_in   = ~d_in;
        ts_exp = sys_timestamp + 2;
        for (int i = 0; i < nbits; i++) begin
            logic b;
            int   first_iv;
            b        = val[NB-1-i];
            first_iv = b ? HALF : FULL;
            if (i == glitch_bit) begin
                step(1);
                d_in = ~d_in;
                step(2);
                d_in = ~d_in;
                step(first_iv - 3);
            end else begin
                step(first_iv);
            end
            d_in = ~d_in;
            if (b) begin
                step(HALF);
                d_in = ~d_in;
            end
        end
    endtask

    // Output monitor: a new frame is presented when data_valid rises or
    // stays high across an accepting edge.
    initial begin : monitor
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk_96MHz);
            #1;
            if (err_pulse) err_seen++;
            if (data_valid && (!prev_valid || data_ready)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got data 0x%0h, expected no frame", data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_data", 64'(data_out), 64'(e.data));
                    check("frame_ts", 64'(frame_ts), 64'(e.ts));
                end
            end
            prev_valid = data_valid;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        logic [TSW-1:0] ts_a, ts_x, ts_g, ts_d;
        int cnt;
        int e0;
        int exp_cnt;

        reset = 1'b1; enable = 1'b1; d_in = 1'b0; e_in = 1'b1;
        data_ready = 1'b0; sys_timestamp = '0;
        step(4);
        reset = 1'b0;
        step(1);
        check("rst_data_out", 64'(data_out), 64'h0);
        check("rst_frame_ts", 64'(frame_ts), 64'h0);
        check("rst_valid", 64'(data_valid), 64'h0);
        check("rst_overflow", 64'(overflow), 64'h0);
        check("rst_err_pulse", 64'(err_pulse), 64'h0);
        check("rst_err_code", 64'(err_code), 64'h0);
        check("rst_err_count", 64'(err_count), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);

        // Frame A: clean decode, latency and hold-off length.
        e_in = 1'b0;
        step(6);
        send_frame(17'h1A5A5, NB, -1, ts_a);
        exp_q.push_back('{17'h1A5A5, ts_a});
        cnt = 0;
        while (!data_valid && cnt < 20) begin step(1); cnt++; end
        check("valid_latency", 64'(cnt), 64'd4);
        cnt = 0;
        while (busy && cnt < HOLD + 20) begin step(1); cnt++; end
        check("holdoff_len", 64'(cnt), 64'(HOLD));
        step(4);
        check("no_err_frame_a", 64'(err_seen), 64'd0);

        // Frame B while A is unread: dropped, overflow set.
        send_frame(17'h0F0F3, NB, -1, ts_x);
        step(HOLD + 10);
        check("ovf_set", 64'(overflow), 64'h1);
        check("ovf_data_kept", 64'(data_out), 64'h1A5A5);
        check("ovf_ts_kept", 64'(frame_ts), 64'(ts_a));
        check("ovf_valid_kept", 64'(data_valid), 64'h1);
        data_ready = 1'b1;
        step(1);
        data_ready = 1'b0;
        check("ready_clears_valid", 64'(data_valid), 64'h0);
        step(1);
        check("ovf_sticky", 64'(overflow), 64'h1);

        // Envelope lost at bit 9.
        e0 = err_seen;
        send_frame(17'h1A5A5, 9, -1, ts_x);
        step(4);
        e_in = 1'b1;
        step(6);
        check("env_err_pulses", 64'(err_seen - e0), 64'd1);
        check("env_err_code", 64'(err_code), 64'd1);
        check("env_idle", 64'(busy), 64'h0);
        check("env_valid_kept", 64'(data_valid), 64'h0);

        // D stuck mid-frame.
        e_in = 1'b0;
        step(6);
        e0 = err_seen;
        send_frame(17'h1A5A5, 3, -1, ts_x);
        step(40);
        check("timeout_pulses", 64'(err_seen - e0), 64'd1);
        check("timeout_code", 64'(err_code), 64'd2);

        // Long interval after a single short one.
        e0 = err_seen;
        step(1); d_in = ~d_in;
        step(HALF); d_in = ~d_in;
        step(FULL); d_in = ~d_in;
        step(8);
        check("phase_pulses", 64'(err_seen - e0), 64'd1);
        check("phase_code", 64'(err_code), 64'd3);
`ifdef BMC_ERROR_COUNTERS_EN
        exp_cnt = 3;
`else
        exp_cnt = 0;
`endif
        check("err_count", 64'(err_count), 64'(exp_cnt));

        // Short glitch right after a bit boundary is ignored.
        step(4);
        send_frame(17'h0B3C6, NB, 6, ts_g);
        exp_q.push_back('{17'h0B3C6, ts_g});
        cnt = 0;
        while (!data_valid && cnt < 20) begin step(1); cnt++; end
        check("glitch_frame_valid", 64'(data_valid), 64'h1);
        step(HOLD + 10);

        // Reset in the middle of a frame.
        send_frame(17'h15C3E, 5, -1, ts_x);
        reset = 1'b1;
        step(2);
        check("midrst_valid", 64'(data_valid), 64'h0);
        check("midrst_data", 64'(data_out), 64'h0);
        check("midrst_ts", 64'(frame_ts), 64'h0);
        check("midrst_overflow", 64'(overflow), 64'h0);
        check("midrst_err_code", 64'(err_code), 64'h0);
        check("midrst_err_count", 64'(err_count), 64'h0);
        check("midrst_busy", 64'(busy), 64'h0);
        reset = 1'b0;
        step(6);
        send_frame(17'h15C3E, NB, -1, ts_d);
        exp_q.push_back('{17'h15C3E, ts_d});
        cnt = 0;
        while (!data_valid && cnt < 20) begin step(1); cnt++; end
        check("post_rst_valid", 64'(data_valid), 64'h1);
        step(HOLD + 10);

        // Enable low mid-frame: back to IDLE, output register retained.
        e0 = err_seen;
        send_frame(17'h1FFFF, 4, -1, ts_x);
        enable = 1'b0;
        step(2);
        check("en_low_idle", 64'(busy), 64'h0);
        check("en_low_valid_kept", 64'(data_valid), 64'h1);
        check("en_low_data_kept", 64'(data_out), 64'h15C3E);
        check("en_low_no_err", 64'(err_seen - e0), 64'd0);
        enable = 1'b1;
        step(5);

        check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
